// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - CPU/loader arbiter for the MMU data port with FENCE.I copy sequencing
`timescale 1ns/1ps

module dm_port_arbiter #(
    parameter int RR_EN         = 1,
    parameter int FENCE_TIMEOUT = 20000
) (
    input  logic        clk,
    input  logic        resetb,

    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_signed,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_be,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,

    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    input  logic [3:0]  l_be,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,

    input  logic        fence_req,
    output logic        fence_ack,
    output logic        fence_err,

    output logic [31:0] dm_addr,
    output logic [31:0] dm_di,
    output logic [3:0]  dm_be,
    output logic        dm_we,
    output logic        is_signed,
    output logic        fence_i,
    input  logic [31:0] dm_do,
    input  logic        fence_i_done
);

    typedef enum logic {
        S_ARB   = 1'b0,
        S_FENCE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } own_t;

    localparam logic [14:0] CNT_LAST = 15'(FENCE_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        last_ldr_q, last_ldr_d;
    logic [14:0] cnt_q, cnt_d;
    own_t        own_q, own_d;

    logic        arb_open;
    logic        cpu_first;
    logic        cpu_sel;
    logic        ldr_sel;
    logic        fence_tmo;

    // Grants are gated by resetb so an asserted reset silences the port without waiting for a clock.
    assign arb_open  = resetb && (state_q == S_ARB) && !fence_req;
    assign cpu_first = (RR_EN == 0) || last_ldr_q || !l_req;
    assign cpu_sel   = arb_open && c_req && cpu_first;
    assign ldr_sel   = arb_open && l_req && !cpu_sel;
    assign fence_tmo = (state_q == S_FENCE) && !fence_i_done && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARB: begin
                if (fence_req) begin
                    state_d = S_FENCE;
                end
            end
            S_FENCE: begin
                if (fence_i_done || fence_tmo) begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        dm_addr   = '0;
        dm_di     = '0;
        dm_be     = '0;
        dm_we     = 1'b0;
        is_signed = 1'b0;
        fence_i   = 1'b0;
        fence_ack = 1'b0;
        fence_err = 1'b0;
        case (state_q)
            S_ARB: begin
                if (cpu_sel) begin
                    c_gnt     = 1'b1;
                    dm_addr   = c_addr;
                    dm_di     = c_wdata;
                    dm_be     = c_be;
                    dm_we     = c_we;
                    is_signed = c_signed;
                end else if (ldr_sel) begin
                    l_gnt     = 1'b1;
                    dm_addr   = l_addr;
                    dm_di     = l_wdata;
                    dm_be     = l_be;
                    dm_we     = l_we;
                end
            end
            S_FENCE: begin
                fence_i   = 1'b1;
                dm_be     = 4'b1111;
                fence_ack = fence_i_done;
                fence_err = fence_tmo;
            end
            default: ;
        endcase
    end

    // The counter only runs while FENCE persists; any exit or ARB cycle leaves it at zero.
    always_comb begin
        cnt_d      = '0;
        last_ldr_d = last_ldr_q;
        own_d      = OWN_NONE;
        if ((state_q == S_FENCE) && (state_d == S_FENCE)) begin
            cnt_d = cnt_q + 15'd1;
        end
        if (cpu_sel) begin
            last_ldr_d = 1'b0;
            own_d      = OWN_CPU;
        end else if (ldr_sel) begin
            last_ldr_d = 1'b1;
            own_d      = OWN_LDR;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            last_ldr_q <= 1'b1;
            cnt_q      <= '0;
            own_q      <= OWN_NONE;
        end else begin
            last_ldr_q <= last_ldr_d;
            cnt_q      <= cnt_d;
            own_q      <= own_d;
        end
    end

    // One-stage owner tag steers the MMU read data back to whoever was granted last cycle.
    assign c_rvalid = (own_q == OWN_CPU);
    assign l_rvalid = (own_q == OWN_LDR);
    assign c_rdata  = c_rvalid ? dm_do : 32'h0;
    assign l_rdata  = l_rvalid ? dm_do : 32'h0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - scoreboard bench for dm_port_arbiter (RR/20000 and fixed/8 instances)
`timescale 1ns/1ps

module tb_dm_port_arbiter;

    typedef struct packed {
        logic        c_req;
        logic        c_we;
        logic        c_signed;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic [3:0]  c_be;
        logic        l_req;
        logic        l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        logic [3:0]  l_be;
        logic        fence_req;
        logic        fence_i_done;
        logic [31:0] dm_do;
    } in_t;

    typedef struct packed {
        logic        c_gnt;
        logic        l_gnt;
        logic        fence_ack;
        logic        fence_err;
        logic        fence_i;
        logic        dm_we;
        logic        is_signed;
        logic [3:0]  dm_be;
        logic [31:0] dm_addr;
        logic [31:0] dm_di;
    } comb_t;

    typedef struct {
        int          cyc;
        bit          ldr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    in_t iv [2];
    in_t nx [2];

    logic        c_gnt_o [2];
    logic        c_rvalid_o [2];
    logic [31:0] c_rdata_o [2];
    logic        l_gnt_o [2];
    logic        l_rvalid_o [2];
    logic [31:0] l_rdata_o [2];
    logic        fence_ack_o [2];
    logic        fence_err_o [2];
    logic [31:0] dm_addr_o [2];
    logic [31:0] dm_di_o [2];
    logic [3:0]  dm_be_o [2];
    logic        dm_we_o [2];
    logic        is_signed_o [2];
    logic        fence_i_o [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dm_port_arbiter #(
            .RR_EN         ((g == 0) ? 1 : 0),
            .FENCE_TIMEOUT ((g == 0) ? 20000 : 8)
        ) u_dut (
            .clk          (clk),
            .resetb       (resetb),
            .c_req        (iv[g].c_req),
            .c_we         (iv[g].c_we),
            .c_signed     (iv[g].c_signed),
            .c_addr       (iv[g].c_addr),
            .c_wdata      (iv[g].c_wdata),
            .c_be         (iv[g].c_be),
            .c_gnt        (c_gnt_o[g]),
            .c_rvalid     (c_rvalid_o[g]),
            .c_rdata      (c_rdata_o[g]),
            .l_req        (iv[g].l_req),
            .l_we         (iv[g].l_we),
            .l_addr       (iv[g].l_addr),
            .l_wdata      (iv[g].l_wdata),
            .l_be         (iv[g].l_be),
            .l_gnt        (l_gnt_o[g]),
            .l_rvalid     (l_rvalid_o[g]),
            .l_rdata      (l_rdata_o[g]),
            .fence_req    (iv[g].fence_req),
            .fence_ack    (fence_ack_o[g]),
            .fence_err    (fence_err_o[g]),
            .dm_addr      (dm_addr_o[g]),
            .dm_di        (dm_di_o[g]),
            .dm_be        (dm_be_o[g]),
            .dm_we        (dm_we_o[g]),
            .is_signed    (is_signed_o[g]),
            .fence_i      (fence_i_o[g]),
            .dm_do        (iv[g].dm_do),
            .fence_i_done (iv[g].fence_i_done)
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_fence [2];
    int          m_cnt [2];
    bit          m_lastl [2];
    exp_t        qa [$];
    exp_t        qb [$];
    logic [31:0] do_nxt = 32'h0;

    function automatic bit rr_of(input int d);
        return d == 0;
    endfunction

    function automatic int to_of(input int d);
        return (d == 0) ? 20000 : 8;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, got, expv, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_fence[d] = 1'b0;
            m_cnt[d]   = 0;
            m_lastl[d] = 1'b1;
            nx[d]      = '0;
        end
        qa.delete();
        qb.delete();
    endtask

    // Reference: decide the expected port behaviour for this cycle, queue the completion, advance.
    task automatic model_step(input int d, input logic [31:0] nd);
        in_t   i;
        comb_t e;
        comb_t g;
        bit    cw;
        bit    lw;
        exp_t  x;
        i  = iv[d];
        e  = '0;
        cw = 1'b0;
        lw = 1'b0;
        if (m_fence[d]) begin
            e.fence_i = 1'b1;
            e.dm_be   = 4'hF;
            if (i.fence_i_done) e.fence_ack = 1'b1;
            else if (m_cnt[d] == to_of(d) - 1) e.fence_err = 1'b1;
        end else if (!i.fence_req) begin
            cw = i.c_req && (!i.l_req || !rr_of(d) || m_lastl[d]);
            lw = i.l_req && !cw;
            if (cw) begin
                e.c_gnt = 1'b1; e.dm_addr = i.c_addr; e.dm_di = i.c_wdata;
                e.dm_be = i.c_be; e.dm_we = i.c_we; e.is_signed = i.c_signed;
            end
            if (lw) begin
                e.l_gnt = 1'b1; e.dm_addr = i.l_addr; e.dm_di = i.l_wdata;
                e.dm_be = i.l_be; e.dm_we = i.l_we;
            end
        end
        g = {c_gnt_o[d], l_gnt_o[d], fence_ack_o[d], fence_err_o[d], fence_i_o[d],
             dm_we_o[d], is_signed_o[d], dm_be_o[d], dm_addr_o[d], dm_di_o[d]};
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL port dut%0d cyc %0d: got %h required %h", d, cyc, g, e);
        end
        if (cw || lw) begin
            x.cyc  = cyc + 1;
            x.ldr  = lw;
            x.data = nd;
            if (d == 0) qa.push_back(x);
            else qb.push_back(x);
        end
        if (m_fence[d]) begin
            if (e.fence_ack || e.fence_err) begin
                m_fence[d] = 1'b0;
                m_cnt[d]   = 0;
                nx[d].fence_req = 1'b0;
            end else begin
                m_cnt[d] = m_cnt[d] + 1;
            end
        end else if (i.fence_req) begin
            m_fence[d] = 1'b1;
            m_cnt[d]   = 0;
        end else begin
            if (cw) begin m_lastl[d] = 1'b0; nx[d].c_req = 1'b0; end
            if (lw) begin m_lastl[d] = 1'b1; nx[d].l_req = 1'b0; end
        end
    endtask

    // nd is the MMU read data presented one cycle later, i.e. what a grant now must return.
    task automatic step(input logic [31:0] nd);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            iv[d]       = nx[d];
            iv[d].dm_do = do_nxt;
        end
        do_nxt = nd;
        @(negedge clk);
        for (int d = 0; d < 2; d++) model_step(d, nd);
    endtask

    task automatic mon(input int d);
        bit          due;
        exp_t        x;
        logic [65:0] got;
        logic [65:0] ex;
        x = '{cyc: 0, ldr: 1'b0, data: 32'h0};
        if (d == 0) due = (qa.size() > 0) && (qa[0].cyc == cyc);
        else due = (qb.size() > 0) && (qb[0].cyc == cyc);
        if (due) begin
            if (d == 0) x = qa.pop_front();
            else x = qb.pop_front();
        end
        ex  = {due && !x.ldr, due && x.ldr,
               (due && !x.ldr) ? x.data : 32'h0, (due && x.ldr) ? x.data : 32'h0};
        got = {c_rvalid_o[d], l_rvalid_o[d], c_rdata_o[d], l_rdata_o[d]};
        n_tests++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL completion dut%0d cyc %0d: got %h required %h", d, cyc, got, ex);
        end
    endtask

    always @(negedge clk) begin
        if (resetb) begin
            for (int d = 0; d < 2; d++) mon(d);
        end
    end

    task automatic chk_quiet(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_gnt"}, 32'({c_gnt_o[d], l_gnt_o[d]}), 32'h0);
            chk({tag, "_rvalid"}, 32'({c_rvalid_o[d], l_rvalid_o[d]}), 32'h0);
            chk({tag, "_fence"}, 32'({fence_i_o[d], fence_ack_o[d], fence_err_o[d], dm_we_o[d]}), 32'h0);
            chk({tag, "_dm_be"}, 32'(dm_be_o[d]), 32'h0);
            chk({tag, "_dm_addr"}, dm_addr_o[d] | dm_di_o[d] | c_rdata_o[d] | l_rdata_o[d], 32'h0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1);
    end

    initial begin
        string s [2];
        int    b_err_at;
        int    b_err_cnt;
        int    ack_cnt [2];

        model_reset();
        for (int d = 0; d < 2; d++) begin
            iv[d]       = '0;
            iv[d].c_req = 1'b1;
            iv[d].l_req = 1'b1;
        end
        #3;
        chk_quiet("reset");
        for (int d = 0; d < 2; d++) iv[d] = '0;
        @(negedge clk);
        resetb = 1'b1;
        step($urandom);
        step($urandom);

        // Contention straight out of reset: CPU first, then alternation only in the RR instance.
        s[0] = "";
        s[1] = "";
        for (int k = 0; k < 4; k++) begin
            for (int d = 0; d < 2; d++) begin
                nx[d].c_req  = 1'b1;
                nx[d].l_req  = 1'b1;
                nx[d].c_addr = $urandom;
                nx[d].l_addr = $urandom;
                nx[d].c_be   = 4'($urandom);
                nx[d].l_be   = 4'($urandom);
            end
            step($urandom);
            for (int d = 0; d < 2; d++)
                s[d] = {s[d], c_gnt_o[d] ? "C" : (l_gnt_o[d] ? "L" : "-")};
        end
        n_tests++;
        if (s[0] != "CLCL") begin
            n_fail++;
            $display("FAIL rr_sequence: got %s required CLCL", s[0]);
        end
        n_tests++;
        if (s[1] != "CCCC") begin
            n_fail++;
            $display("FAIL fixed_sequence: got %s required CCCC", s[1]);
        end

        // CPU write, then FENCE.I while the loader waits.
        for (int d = 0; d < 2; d++) begin
            nx[d].c_req    = 1'b1;
            nx[d].c_we     = 1'b1;
            nx[d].c_signed = 1'b0;
            nx[d].c_addr   = 32'h80000004;
            nx[d].c_wdata  = $urandom;
            nx[d].c_be     = 4'hF;
            nx[d].l_req    = 1'b1;
        end
        step($urandom);
        for (int d = 0; d < 2; d++) chk("wr_gnt", 32'({c_gnt_o[d], dm_we_o[d]}), 32'h3);
        for (int d = 0; d < 2; d++) nx[d].fence_req = 1'b1;
        step($urandom);
        for (int d = 0; d < 2; d++)
            chk("fence_entry", 32'({c_rvalid_o[d], fence_i_o[d], l_gnt_o[d]}), 32'h4);
        step($urandom);
        for (int d = 0; d < 2; d++) begin
            chk("fence_i_on", 32'({fence_i_o[d], l_gnt_o[d]}), 32'h2);
            chk("fence_dm", dm_addr_o[d] | 32'(dm_be_o[d]), 32'hF);
        end

        b_err_at   = -1;
        b_err_cnt  = 0;
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
        for (int k = 2; k <= 16385; k++) begin
            step($urandom);
            if (fence_err_o[1]) begin
                b_err_cnt++;
                if (b_err_at < 0) b_err_at = k;
            end
            if (fence_ack_o[0]) ack_cnt[0]++;
            if (fence_ack_o[1]) ack_cnt[1]++;
        end
        chk("timeout_cycle", 32'(b_err_at), 32'd8);
        chk("timeout_once", 32'(b_err_cnt), 32'd1);
        chk("ack_early", 32'(ack_cnt[0]), 32'd0);
        chk("long_fence_i", 32'(fence_i_o[0]), 32'd1);
        nx[0].fence_i_done = 1'b1;
        nx[1].fence_i_done = 1'b1;
        step($urandom);
        if (fence_ack_o[1]) ack_cnt[1]++;
        chk("done_ack", 32'({fence_ack_o[0], fence_i_o[0]}), 32'h3);
        nx[0].fence_i_done = 1'b0;
        nx[1].fence_i_done = 1'b0;
        step($urandom);
        chk("after_ack", 32'({fence_i_o[0], fence_ack_o[0], l_gnt_o[0]}), 32'h1);
        chk("stray_done_ack", 32'(ack_cnt[1]), 32'd0);

        // Single CPU read with known MMU data.
        step($urandom);
        for (int d = 0; d < 2; d++) begin
            nx[d]        = '0;
            nx[d].c_req  = 1'b1;
            nx[d].c_addr = 32'h00000010;
            nx[d].c_be   = 4'hF;
        end
        step(32'hDEADBEEF);
        for (int d = 0; d < 2; d++) chk("rd_gnt_addr", c_gnt_o[d] ? dm_addr_o[d] : 32'hFFFFFFFF, 32'h10);
        step($urandom);
        for (int d = 0; d < 2; d++) begin
            chk("rd_rdata", c_rdata_o[d], 32'hDEADBEEF);
            chk("rd_rvalid", 32'({c_rvalid_o[d], l_rvalid_o[d]}), 32'h2);
        end

        for (int k = 0; k < 3000; k++) begin
            for (int d = 0; d < 2; d++) begin
                if (!nx[d].c_req && ($urandom % 2 == 0)) begin
                    nx[d].c_req    = 1'b1;
                    nx[d].c_we     = 1'($urandom);
                    nx[d].c_signed = 1'($urandom);
                    nx[d].c_addr   = $urandom;
                    nx[d].c_wdata  = $urandom;
                    nx[d].c_be     = 4'($urandom);
                end
                if (!nx[d].l_req && ($urandom % 2 == 0)) begin
                    nx[d].l_req   = 1'b1;
                    nx[d].l_we    = 1'($urandom);
                    nx[d].l_addr  = $urandom;
                    nx[d].l_wdata = $urandom;
                    nx[d].l_be    = 4'($urandom);
                end
                if (!nx[d].fence_req && !m_fence[d] && ($urandom % 50 == 0)) nx[d].fence_req = 1'b1;
                nx[d].fence_i_done = ($urandom % 8 == 0);
            end
            step($urandom);
        end

        // Drain outstanding work, then reset in the middle of a fence.
        for (int k = 0; k < 6; k++) begin
            for (int d = 0; d < 2; d++) nx[d].fence_i_done = 1'b1;
            step($urandom);
        end
        for (int d = 0; d < 2; d++) begin
            nx[d].fence_i_done = 1'b0;
            nx[d].fence_req    = 1'b1;
        end
        step($urandom);
        step($urandom);
        step($urandom);
        for (int d = 0; d < 2; d++) chk("pre_reset_fence", 32'(fence_i_o[d]), 32'd1);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            iv[d].c_req = 1'b1;
            iv[d].l_req = 1'b1;
        end
        #2;
        resetb = 1'b0;
        #1;
        chk_quiet("async_reset");
        for (int d = 0; d < 2; d++) iv[d] = '0;
        model_reset();
        @(posedge clk);
        #2;
        resetb = 1'b1;
        step($urandom);
        for (int d = 0; d < 2; d++) begin
            nx[d].c_req = 1'b1;
            nx[d].l_req = 1'b1;
        end
        step($urandom);
        for (int d = 0; d < 2; d++) chk("post_reset_cpu", 32'({c_gnt_o[d], l_gnt_o[d]}), 32'h2);
        step($urandom);
        step($urandom);
        step($urandom);
        chk("queues_empty", 32'(qa.size() + qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_port_arbiter.md
DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1; 1 = round-robin between requesters, 0 = fixed CPU priority.
REQ-002 SHALL have parameter FENCE_TIMEOUT, default 20000; maximum cycles spent in FENCE before abort.
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge
- resetb  in  1  asynchronous, active-low reset
- c_req, c_we, c_signed  in  1 each  CPU data request, write enable, sign-extend
- c_addr, c_wdata  in  32 each  CPU byte address, write data
- c_be  in  4  CPU byte enable
- c_gnt, c_rvalid  out  1 each  CPU grant, read/write completion
- c_rdata  out  32  CPU read data
- l_req, l_we, l_addr, l_wdata, l_be, l_gnt, l_rvalid, l_rdata  as c_*  loader (UART/debug) requester; no sign-extend, always unsigned
- fence_req  in  1  CPU FENCE.I request, level, held until fence_ack
- fence_ack, fence_err  out  1 each  one-cycle pulses: copy finished, copy timed out
- dm_addr, dm_di  out  32 each  to MMU data port
- dm_be  out  4  to MMU
- dm_we, is_signed, fence_i  out  1 each  to MMU
- dm_do  in  32  MMU read data, valid one cycle after the access
- fence_i_done  in  1  MMU copy-complete indication

Function
REQ-004 SHALL implement states ARB and FENCE; reset state ARB.
REQ-005 In ARB, grant SHALL be combinational in the request cycle: at most one of c_gnt/l_gnt high per cycle.
REQ-006 With RR_EN=1 and both requesting, the requester not granted most recently SHALL win; last-winner register resets to "loader", so the CPU wins the first contention.
REQ-007 With RR_EN=0, c_req SHALL always win over l_req.
REQ-008 Granted requester's addr/wdata/be/we SHALL drive dm_*; is_signed = c_signed for CPU, 0 for loader.
REQ-009 With no grant: dm_we=0, dm_be=4'b0000, dm_addr=0, dm_di=0, is_signed=0.
REQ-010 The cycle after a grant, the owner's *_rvalid SHALL pulse for one cycle (reads and writes); *_rdata = dm_do that cycle, 0 otherwise.
REQ-011 Back-to-back grants SHALL be allowed every cycle; owner tag SHALL be pipelined one stage so rvalid/rdata route to the correct requester.
REQ-012 fence_req in ARB SHALL take priority: no grant that cycle, next state FENCE; an access granted the previous cycle still completes its rvalid.
REQ-013 In FENCE: fence_i=1, dm_addr=0, dm_we=0, dm_be=4'b1111, no grants, 15-bit cycle counter incrementing from 0.
REQ-014 fence_i_done=1 in FENCE SHALL pulse fence_ack, drop fence_i the next cycle, return to ARB, clear counter.
REQ-015 Counter reaching FENCE_TIMEOUT-1 without fence_i_done SHALL pulse fence_err, drop fence_i, return to ARB.
REQ-016 fence_i_done outside FENCE SHALL be ignored.
REQ-017 fence_req deasserted mid-FENCE SHALL NOT abort; completion or timeout only.
REQ-018 A requester SHALL hold its request signals stable until granted; the arbiter stores no request.

Reset
REQ-019 resetb low SHALL immediately force: state ARB, last-winner = loader, counter 0, owner tag none, all gnt/rvalid/fence_ack/fence_err/fence_i/dm_we = 0, all data outputs and dm_be = 0.
REQ-020 Reset mid-FENCE SHALL drop fence_i asynchronously; no fence_ack or fence_err pulse.

Verification
REQ-021 c_req only, read 0x00000010, be 1111; dm_do=0xDEADBEEF next cycle -> c_gnt cycle 0, c_rvalid cycle 1, c_rdata=0xDEADBEEF, l_rvalid=0.
REQ-022 Both requesting 4 cycles, RR_EN=1 -> grants C,L,C,L; with RR_EN=0 -> C,C,C,C.
REQ-023 CPU write 0x80000004 in cycle 0, fence_req in cycle 1 -> c_rvalid cycle 1, fence_i high from cycle 2, dm_addr=0, l_req ignored until ack.
REQ-024 In FENCE, fence_i_done after 16385 cycles -> fence_ack one pulse, fence_i low next cycle, pending l_req granted the cycle after.
REQ-025 FENCE_TIMEOUT=8, fence_i_done never -> fence_err pulse on 8th FENCE cycle, fence_ack never, return to ARB.
REQ-026 resetb low mid-FENCE -> fence_i, gnt, rvalid all 0 without a clock edge; after release, first contention grants CPU.
